// File: rtl/fila_pedidos_if.sv
// Call-panel / elevator-datapath bundle for the request queue.
// master = the side driving requests and pronto; slave = the queue itself.
interface fila_pedidos_if;
   logic       registra;
   logic [3:0] origem_in;
   logic [3:0] destino_in;
   logic       pronto;
   logic [3:0] origem;
   logic [3:0] destino;
   logic       novaEntrada;
   logic       vazio;
   logic       cheio;
   logic [2:0] contagem;
   logic       descartado;

   modport master (
      output registra, origem_in, destino_in, pronto,
      input  origem, destino, novaEntrada, vazio, cheio, contagem, descartado
   );

   modport slave (
      input  registra, origem_in, destino_in, pronto,
      output origem, destino, novaEntrada, vazio, cheio, contagem, descartado
   );
endinterface

// File: rtl/fila_pedidos.sv
// Elevator request queue: captures {origem,destino} pairs from the call panel
// into a 4-entry FIFO and presents the head to the downstream datapath as a
// HOLD-cycle novaEntrada strobe followed by a one-cycle low gap.
module fila_pedidos #(
   parameter int unsigned HOLD = 4
) (
   input logic           clock,
   input logic           reset,
   fila_pedidos_if.slave bus
);

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      APRESENTA = 2'd1,
      INTERVALO = 2'd2
   } estado_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

   estado_t    state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] count_q, count_d;
   logic [7:0] mem_q [4];
   logic [7:0] mem_d [4];
   logic       registra_q, registra_d;
   logic       armed_q, armed_d;
   logic       cap_q, cap_d;
   logic [7:0] cap_data_q, cap_data_d;
   logic       descartado_q, descartado_d;
   logic       vazio_q, vazio_d;
   logic       cheio_q, cheio_d;
   logic       pop;
   logic       push;
   logic       distinct;

   // Edge detector for registra; armed stays low after reset until registra
   // has been seen low, so a level already high at release is ignored.
   // The request data is latched together with the pulse.
   always_comb begin
      registra_d = bus.registra;
      armed_d    = armed_q | ~bus.registra;
      cap_d      = bus.registra & ~registra_q & armed_q;
      cap_data_d = cap_data_q;
      if (cap_d) begin
         cap_data_d = {bus.origem_in, bus.destino_in};
      end
   end

   // FIFO bookkeeping: a pending capture is written when it names two
   // different floors and there is room, where a pop in the same cycle frees
   // the slot; otherwise it is reported through descartado.
   always_comb begin
      pop          = (state_q == APRESENTA) && (hold_cnt_q == HOLD_LAST);
      distinct     = cap_data_q[7:4] != cap_data_q[3:0];
      push         = cap_q & distinct & (~cheio_q | pop);
      descartado_d = cap_q & ~push;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = cap_data_q;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
      vazio_d = (count_d == 3'd0);
      cheio_d = (count_d == 3'd4);
   end

   // Presentation sequencer: wait for data and a ready datapath, hold the
   // strobe for HOLD cycles popping on the last one, then force a low gap.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = 8'd0;
      unique case (state_q)
         OCIOSO: begin
            if (!vazio_q && bus.pronto) begin
               state_d = APRESENTA;
            end
         end
         APRESENTA: begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            if (pop) begin
               state_d    = INTERVALO;
               hold_cnt_d = 8'd0;
            end
         end
         INTERVALO: begin
            state_d = OCIOSO;
         end
         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   // State register; reset discards queued and in-flight requests at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= OCIOSO;
         hold_cnt_q   <= 8'd0;
         rd_ptr_q     <= 2'd0;
         wr_ptr_q     <= 2'd0;
         count_q      <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 8'd0;
         end
         registra_q   <= 1'b0;
         armed_q      <= 1'b0;
         cap_q        <= 1'b0;
         cap_data_q   <= 8'd0;
         descartado_q <= 1'b0;
         vazio_q      <= 1'b1;
         cheio_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         mem_q        <= mem_d;
         registra_q   <= registra_d;
         armed_q      <= armed_d;
         cap_q        <= cap_d;
         cap_data_q   <= cap_data_d;
         descartado_q <= descartado_d;
         vazio_q      <= vazio_d;
         cheio_q      <= cheio_d;
      end
   end

   assign bus.origem      = vazio_q ? 4'd0 : mem_q[rd_ptr_q][7:4];
   assign bus.destino     = vazio_q ? 4'd0 : mem_q[rd_ptr_q][3:0];
   assign bus.novaEntrada = (state_q == APRESENTA);
   assign bus.vazio       = vazio_q;
   assign bus.cheio       = cheio_q;
   assign bus.contagem    = count_q;
   assign bus.descartado  = descartado_q;

endmodule

// File: tb/tb_fila_pedidos.sv
// Bench for fila_pedidos: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fila_pedidos;

   localparam int HOLD = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fila_pedidos_if bus ();

   fila_pedidos #(.HOLD(HOLD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;
   bit done        = 1'b0;

   // Reference model: the queue contents, the pending capture, and how many
   // strobe cycles remain in the current presentation.
   logic [7:0] mq[$];
   bit         m_prev      = 1'b0;
   bit         m_armed     = 1'b0;
   bit         m_pend      = 1'b0;
   logic [7:0] m_pend_data = 8'd0;
   bit         m_desc      = 1'b0;
   int         m_hi_left   = 0;
   bit         m_gap       = 1'b0;
   bit         m_pop;
   bit         m_acc;
   int         m_size;

   // Model update on each clock edge, cleared asynchronously with the DUT.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_prev    = 1'b0;
         m_armed   = 1'b0;
         m_pend    = 1'b0;
         m_desc    = 1'b0;
         m_hi_left = 0;
         m_gap     = 1'b0;
      end else begin
         m_size = mq.size();
         m_pop  = (m_hi_left == 1);
         m_acc  = m_pend && (m_pend_data[7:4] != m_pend_data[3:0]) && (m_size < 4 || m_pop);
         m_desc = m_pend && !m_acc;
         if (m_hi_left > 0) begin
            m_hi_left--;
            if (m_hi_left == 0) m_gap = 1'b1;
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (m_size > 0 && bus.pronto) begin
            m_hi_left = HOLD;
         end
         if (m_pop) void'(mq.pop_front());
         if (m_acc) mq.push_back(m_pend_data);
         m_pend = bus.registra && !m_prev && m_armed;
         if (m_pend) m_pend_data = {bus.origem_in, bus.destino_in};
         m_armed = m_armed || !bus.registra;
         m_prev  = bus.registra;
      end
   end

   logic [7:0]  cmp_head;
   logic [14:0] exp_v;
   logic [14:0] act_v;

   // Every-cycle comparison of all outputs against the model, mid-cycle.
   always @(negedge clock) begin
      if (!done) begin
         cmp_head = (mq.size() > 0) ? mq[0] : 8'h00;
         exp_v = {m_hi_left > 0, cmp_head[7:4], cmp_head[3:0], mq.size() == 0,
                  mq.size() == 4, 3'(mq.size()), m_desc};
         act_v = {bus.novaEntrada, bus.origem, bus.destino, bus.vazio,
                  bus.cheio, bus.contagem, bus.descartado};
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL model_cycle t=%0t got=%h want=%h (nova,org,dst,vazio,cheio,cnt,desc)",
                     $time, act_v, exp_v);
         end
      end
   end

   task automatic check_output(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input bit reg_lvl, input int o, input int d);
      bus.registra   = reg_lvl;
      bus.origem_in  = 4'(o);
      bus.destino_in = 4'(d);
   endtask

   // One registra pulse; returns two cycles later, when the outcome is visible.
   task automatic register_req(input int o, input int d, output int desc_seen);
      apply_stimulus(1'b1, o, d);
      @(negedge clock);
      bus.registra = 1'b0;
      @(negedge clock);
      desc_seen = int'(bus.descartado);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1;
      check_output("rst_nova", int'(bus.novaEntrada), 0);
      check_output("rst_vazio", int'(bus.vazio), 1);
      check_output("rst_cnt", int'(bus.contagem), 0);
      check_output("rst_org_dst", int'({bus.origem, bus.destino}), 0);
      check_output("rst_cheio_desc", int'({bus.cheio, bus.descartado}), 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   int desc;
   int first_hi, hi_cnt, seen_o, seen_d, k;
   int n_rise, low_run, gap;
   int hl[2];
   int ro[2];
   int rd[2];
   bit prev_nova;

   initial begin
      bus.registra   = 1'b0;
      bus.origem_in  = 4'd0;
      bus.destino_in = 4'd0;
      bus.pronto     = 1'b0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      check_output("reset_vazio", int'(bus.vazio), 1);
      check_output("reset_contagem", int'(bus.contagem), 0);
      check_output("reset_nova", int'(bus.novaEntrada), 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Single request into an empty queue with the datapath ready.
      $display("[TB] single request (2,7)");
      bus.pronto = 1'b1;
      apply_stimulus(1'b1, 2, 7);
      first_hi = -1; hi_cnt = 0; seen_o = -1; seen_d = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (c == 1) bus.registra = 1'b0;
         if (bus.novaEntrada) begin
            if (first_hi < 0) first_hi = c;
            hi_cnt++;
            seen_o = int'(bus.origem);
            seen_d = int'(bus.destino);
         end
      end
      check_output("latency_2_7", first_hi, 3);
      check_output("hold_cycles_2_7", hi_cnt, 4);
      check_output("origem_2_7", seen_o, 2);
      check_output("destino_2_7", seen_d, 7);
      check_output("vazio_after_2_7", int'(bus.vazio), 1);

      // Filling with the datapath busy, including a same-floor rejection.
      $display("[TB] fill with pronto low");
      bus.pronto = 1'b0;
      register_req(1, 5, desc);
      register_req(3, 0, desc);
      register_req(9, 4, desc);
      check_output("cnt_after_three", int'(bus.contagem), 3);
      register_req(6, 6, desc);
      check_output("desc_same_floor", desc, 1);
      check_output("cnt_after_6_6", int'(bus.contagem), 3);
      register_req(8, 2, desc);
      check_output("desc_8_2", desc, 0);
      check_output("cnt_full", int'(bus.contagem), 4);
      check_output("cheio_full", int'(bus.cheio), 1);

      // Capture landing on the pop cycle of a full queue is accepted.
      $display("[TB] capture on last presentation cycle while full");
      bus.pronto = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k < HOLD; c++) begin
         @(negedge clock);
         if (bus.novaEntrada) begin
            k++;
            if (k == HOLD - 1) apply_stimulus(1'b1, 0, 3);
            if (k == HOLD) begin
               bus.registra = 1'b0;
               bus.pronto   = 1'b0;
            end
         end
      end
      check_output("pres_reached_034", k, HOLD);
      @(negedge clock);
      check_output("cnt_034", int'(bus.contagem), 4);
      check_output("desc_034", int'(bus.descartado), 0);
      check_output("head_034", int'({bus.origem, bus.destino}), 8'h30);

      // Two queued entries presented back to back.
      $display("[TB] two presentations");
      pulse_reset();
      register_req(1, 5, desc);
      register_req(3, 0, desc);
      bus.pronto = 1'b1;
      n_rise = 0; low_run = 0; gap = -1; prev_nova = 1'b0;
      hl[0] = 0; hl[1] = 0; ro[0] = 0; ro[1] = 0; rd[0] = 0; rd[1] = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (bus.novaEntrada) begin
            if (!prev_nova) begin
               if (n_rise == 1) gap = low_run;
               if (n_rise < 2) begin
                  ro[n_rise] = int'(bus.origem);
                  rd[n_rise] = int'(bus.destino);
               end
               n_rise++;
            end
            if (n_rise <= 2) hl[n_rise-1]++;
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_nova = bus.novaEntrada;
      end
      check_output("rises_035", n_rise, 2);
      check_output("first_035", ro[0] * 16 + rd[0], 8'h15);
      check_output("second_035", ro[1] * 16 + rd[1], 8'h30);
      check_output("len0_035", hl[0], 4);
      check_output("len1_035", hl[1], 4);
      check_output("gap_ok_035", int'(gap >= 1), 1);

      // registra held high captures once; already-high level after reset ignored.
      $display("[TB] held registra and reset with registra high");
      bus.pronto = 1'b0;
      apply_stimulus(1'b1, 4, 9);
      repeat (20) @(negedge clock);
      check_output("held_once_036", int'(bus.contagem), 1);
      pulse_reset();
      repeat (5) @(negedge clock);
      check_output("high_after_reset_031", int'(bus.contagem), 0);
      bus.registra = 1'b0;
      @(negedge clock);
      register_req(4, 9, desc);
      check_output("rearm_031", int'(bus.contagem), 1);

      // Reset in the second presentation cycle kills the request.
      $display("[TB] reset mid presentation");
      bus.pronto = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k < 2; c++) begin
         @(negedge clock);
         if (bus.novaEntrada) k++;
      end
      check_output("pres_reached_037", k, 2);
      pulse_reset();
      hi_cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clock);
         if (bus.novaEntrada) hi_cnt++;
      end
      check_output("no_emit_037", hi_cnt, 0);

      // Randomized traffic with occasional resets.
      $display("[TB] random traffic");
      for (int c = 0; c < 1200; c++) begin
         @(negedge clock);
         if ($urandom_range(0, 2) == 0) bus.registra = ~bus.registra;
         bus.origem_in  = 4'($urandom_range(0, 3));
         bus.destino_in = 4'($urandom_range(0, 3));
         bus.pronto     = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end

      @(negedge clock);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fila_pedidos.md
FILA_PEDIDOS -- requirements
Module: fila_pedidos

Interface
REQ-001 Parameter HOLD, default 4: cycles novaEntrada is held high per presented request; legal range 1..255.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 registra  input  1  level from call panel; a request is captured on its rising edge.
REQ-005 origem_in  input  4  origin floor of the request being registered.
REQ-006 destino_in  input  4  destination floor of the request being registered.
REQ-007 pronto  input  1  high when the downstream elevator datapath can accept a new request.
REQ-008 origem  output  4  origin floor of the request at the queue head.
REQ-009 destino  output  4  destination floor of the request at the queue head.
REQ-010 novaEntrada  output  1  level strobe to downstream; downstream edge-detects its rise.
REQ-011 vazio  output  1  queue holds zero entries.
REQ-012 cheio  output  1  queue holds four entries.
REQ-013 contagem  output  3  number of stored entries, 0..4.
REQ-014 descartado  output  1  one-cycle pulse when a captured request is rejected.

Function
REQ-015 Storage: 4-entry FIFO of {origem,destino} pairs (8 bits each); 2-bit read/write pointers, wrap 3->0; separate 3-bit occupancy count.
REQ-016 Capture: internal one-cycle pulse on the registra 0->1 transition (registered previous value); holding registra high captures only once.
REQ-017 On a capture pulse, the entry is written at the write pointer when origem_in != destino_in and the queue is not full.
REQ-018 A capture with origem_in == destino_in, or while cheio=1 with no pop in the same cycle, is dropped and descartado=1 in the cycle after the pulse.
REQ-019 A capture and a pop in the same cycle are both performed: count unchanged, both pointers advance; this also applies when full.
REQ-020 origem/destino always show the entry at the read pointer; value when vazio=1 is 0.
REQ-021 FSM states OCIOSO, APRESENTA, INTERVALO.
REQ-022 OCIOSO: novaEntrada=0; go to APRESENTA when vazio=0 and pronto=1; hold-counter loaded with 0.
REQ-023 APRESENTA: novaEntrada=1; hold-counter increments each cycle; after HOLD cycles in this state, pop the head (on the last cycle) and go to INTERVALO.
REQ-024 origem/destino are stable for all HOLD cycles of APRESENTA; a capture during APRESENTA never alters the head.
REQ-025 INTERVALO: novaEntrada=0 for exactly one cycle, then go to OCIOSO; a new presentation therefore always has a low gap of at least 1 cycle.
REQ-026 pronto is sampled only in OCIOSO; deassertion during APRESENTA does not abort the presentation.
REQ-027 Latency: registration into an empty queue with pronto=1 -> novaEntrada rises 2 cycles after the registra rising edge is sampled.
REQ-028 vazio, cheio, contagem are registered and reflect the count after each clock edge.

Reset
REQ-029 reset low: pointers, count, hold-counter and registra history cleared; FSM=OCIOSO; novaEntrada=0, descartado=0, origem=destino=0, vazio=1, cheio=0, contagem=0.
REQ-030 reset asserted mid-APRESENTA drops the in-flight request and all queued entries; no pop pulse is produced.
REQ-031 After reset release, a registra that is already high is not captured until it goes low and high again.

Verification
REQ-032 Empty queue, pronto=1, register (2,7) -> novaEntrada high 4 cycles with origem=2, destino=7, then low; vazio=1 afterwards.
REQ-033 pronto=0, register (1,5),(3,0),(9,4),(6,6),(8,2) -> contagem=3 after the third, descartado on (6,6), contagem=4 cheio=1 after (8,2).
REQ-034 Queue full, pronto=1: register (0,3) during the last APRESENTA cycle -> accepted, contagem stays 4, descartado=0.
REQ-035 Queue with (1,5),(3,0), pronto=1 -> two novaEntrada pulses of 4 cycles separated by at least 1 low cycle, values in order.
REQ-036 Hold registra high 20 cycles -> exactly one entry captured.
REQ-037 Assert reset during the 2nd APRESENTA cycle -> all outputs at reset values asynchronously; no request emitted after release.
